i2c_target: RTL and testbench

- Synthesizable I2C target (responder); the counterpart to the SoC's i2c master peripheral.
- Holds a small byte register file. An external master writes or reads it over SCL/SDA using a pointer byte with auto-increment.
- A local port lets SoC logic or the bench read and modify the same registers.
- Used as an on-board loopback target for the i2c master and as a reusable peripheral.

---
 rtl/i2c_target_pkg.sv | 26 ++
 rtl/i2c_bus_sync.sv | 46 ++++
 rtl/i2c_target.sv | 228 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target: FSM states, ACK/NACK levels, default address.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

    localparam logic       ACK          = 1'b0;
    localparam logic       NACK         = 1'b1;
    localparam logic [6:0] DEF_TGT_ADDR = 7'h50;

    // Open-drain: placing a 0 on the bus means enabling the pull-down.
    function automatic logic drive_bit(input logic b);
        return ~b;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk and derives SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl_s;
    logic                   w_sda_s;

    // Reset to 1 so an idle bus produces no spurious edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_prev <= w_scl_s;
            r_sda_prev <= w_sda_s;
        end
    end

    assign w_scl_s   = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s   = r_sda_sync[SYNC_STAGES-1];
    assign sda_s     = w_sda_s;
    assign scl_rise  = w_scl_s & ~r_scl_prev;
    assign scl_fall  = ~w_scl_s & r_scl_prev;
    assign start_det = w_scl_s & r_scl_prev & r_sda_prev & ~w_sda_s;
    assign stop_det  = w_scl_s & r_scl_prev & ~r_sda_prev & w_sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target with a byte register file, pointer auto-increment and a local access port.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR    = DEF_TGT_ADDR,
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe_o,
    input  logic [AW-1:0] loc_addr_i,
    input  logic          loc_we_i,
    input  logic [7:0]    loc_wdata_i,
    output logic [7:0]    loc_rdata_o,
    output logic          wr_evt_o,
    output logic [AW-1:0] wr_idx_o,
    output logic          busy_o
);

    logic w_scl_rise, w_scl_fall, w_start_det, w_stop_det, w_sda_s;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (w_scl_rise),
        .scl_fall (w_scl_fall),
        .start_det(w_start_det),
        .stop_det (w_stop_det),
        .sda_s    (w_sda_s)
    );

    i2c_state_e    r_state, w_state_next;
    logic [3:0]    r_bit_cnt, w_bit_cnt_next;
    logic [7:0]    r_shift, w_shift_next;
    logic [AW-1:0] r_ptr, w_ptr_next;
    logic          r_rw, w_rw_next;
    logic          r_ack_drv, w_ack_drv_next;
    logic          r_sda_oe, w_sda_oe_next;
    logic          r_wr_evt, w_wr_evt_next;
    logic [AW-1:0] r_wr_idx, w_wr_idx_next;
    logic          r_busy, w_busy_next;
    logic          w_commit;
    logic [7:0]    w_byte_in;
    logic [7:0]    w_rd_byte;
    logic [7:0]    r_regs [DEPTH];

    assign w_byte_in = {r_shift[6:0], w_sda_s};
    assign w_rd_byte = r_regs[r_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_ptr     <= '0;
            r_rw      <= 1'b0;
            r_ack_drv <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_wr_evt  <= 1'b0;
            r_wr_idx  <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_ptr     <= w_ptr_next;
            r_rw      <= w_rw_next;
            r_ack_drv <= w_ack_drv_next;
            r_sda_oe  <= w_sda_oe_next;
            r_wr_evt  <= w_wr_evt_next;
            r_wr_idx  <= w_wr_idx_next;
            r_busy    <= w_busy_next;
        end
    end

    // Ack states see two falling edges: the first starts driving, the second ends the ack clock.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_ptr_next     = r_ptr;
        w_rw_next      = r_rw;
        w_ack_drv_next = r_ack_drv;
        w_sda_oe_next  = r_sda_oe;
        w_wr_evt_next  = 1'b0;
        w_wr_idx_next  = r_wr_idx;
        w_busy_next    = r_busy;
        w_commit       = 1'b0;
        if (w_start_det) begin
            w_state_next   = ST_ADDR;
            w_bit_cnt_next = 4'd0;
            w_ack_drv_next = 1'b0;
            w_sda_oe_next  = 1'b0;
            w_busy_next    = 1'b0;
        end else if (w_stop_det) begin
            w_state_next   = ST_IDLE;
            w_ack_drv_next = 1'b0;
            w_sda_oe_next  = 1'b0;
            w_busy_next    = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: if (w_scl_rise) begin
                    w_shift_next   = w_byte_in;
                    w_bit_cnt_next = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        if (w_byte_in[7:1] == TGT_ADDR) begin
                            w_busy_next    = 1'b1;
                            w_rw_next      = w_byte_in[0];
                            w_ack_drv_next = 1'b0;
                            w_state_next   = ST_ADDR_ACK;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK: if (w_scl_fall) begin
                    if (!r_ack_drv) begin
                        w_sda_oe_next  = drive_bit(ACK);
                        w_ack_drv_next = 1'b1;
                    end else begin
                        w_ack_drv_next = 1'b0;
                        w_bit_cnt_next = 4'd0;
                        if (r_rw) begin
                            w_shift_next  = w_rd_byte;
                            w_sda_oe_next = drive_bit(w_rd_byte[7]);
                            w_state_next  = ST_RDATA;
                        end else begin
                            w_sda_oe_next = 1'b0;
                            w_state_next  = ST_PTR;
                        end
                    end
                end
                ST_PTR, ST_WDATA: if (w_scl_rise) begin
                    w_shift_next   = w_byte_in;
                    w_bit_cnt_next = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        w_ack_drv_next = 1'b0;
                        if (r_state == ST_PTR) begin
                            w_ptr_next   = w_byte_in[AW-1:0];
                            w_state_next = ST_PTR_ACK;
                        end else begin
                            w_state_next = ST_WDATA_ACK;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: if (w_scl_fall) begin
                    if (!r_ack_drv) begin
                        w_sda_oe_next  = drive_bit(ACK);
                        w_ack_drv_next = 1'b1;
                    end else begin
                        w_ack_drv_next = 1'b0;
                        w_sda_oe_next  = 1'b0;
                        w_bit_cnt_next = 4'd0;
                        w_state_next   = ST_WDATA;
                        if (r_state == ST_WDATA_ACK) begin
                            w_commit      = 1'b1;
                            w_wr_evt_next = 1'b1;
                            w_wr_idx_next = r_ptr;
                            w_ptr_next    = r_ptr + 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_oe_next  = 1'b0;
                            w_ack_drv_next = 1'b0;
                            w_state_next   = ST_RDATA_ACK;
                        end else begin
                            w_shift_next  = {r_shift[6:0], 1'b0};
                            w_sda_oe_next = drive_bit(r_shift[6]);
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_ptr_next = r_ptr + 1'b1;
                        if (w_sda_s == NACK) begin
                            w_state_next = ST_WAIT_STOP;
                        end else begin
                            w_ack_drv_next = 1'b1;
                        end
                    end else if (w_scl_fall && r_ack_drv) begin
                        w_ack_drv_next = 1'b0;
                        w_bit_cnt_next = 4'd0;
                        w_shift_next   = w_rd_byte;
                        w_sda_oe_next  = drive_bit(w_rd_byte[7]);
                        w_state_next   = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // The I2C commit is assigned last so it wins a same-index collision with the local port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            if (loc_we_i) begin
                r_regs[loc_addr_i] <= loc_wdata_i;
            end
            if (w_commit) begin
                r_regs[r_ptr] <= r_shift;
            end
        end
    end

    assign loc_rdata_o = r_regs[loc_addr_i];
    assign sda_oe_o    = r_sda_oe;
    assign wr_evt_o    = r_wr_evt;
    assign wr_idx_o    = r_wr_idx;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Directed and randomized bus transactions against a register-file model of the target.
module tb_i2c_target;
    import i2c_target_pkg::*;

    localparam int         DEPTH   = 16;
    localparam int         Q       = 8;
    localparam logic [7:0] AW_BYTE = 8'hA0;
    localparam logic [7:0] AR_BYTE = 8'hA1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [3:0] loc_addr = 4'd0;
    logic       loc_we = 1'b0;
    logic [7:0] loc_wdata = 8'h00;
    logic [7:0] loc_rdata;
    logic       wr_evt;
    logic [3:0] wr_idx;
    logic       busy;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         oe_cnt = 0;
    int         evt_n = 0;
    logic [3:0] evt_log [64];
    logic [7:0] ref_regs [DEPTH];
    int         ref_ptr = 0;
    logic [7:0] wbuf [8];

    always #5 clk = ~clk;
    assign sda_bus = m_sda & ~sda_oe;

    i2c_target #(
        .TGT_ADDR   (7'h50),
        .DEPTH      (DEPTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (m_scl),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe),
        .loc_addr_i (loc_addr),
        .loc_we_i   (loc_we),
        .loc_wdata_i(loc_wdata),
        .loc_rdata_o(loc_rdata),
        .wr_evt_o   (wr_evt),
        .wr_idx_o   (wr_idx),
        .busy_o     (busy)
    );

    always @(negedge clk) begin
        if (sda_oe === 1'b1) oe_cnt++;
        if (wr_evt === 1'b1) begin
            evt_log[evt_n % 64] = wr_idx;
            evt_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        m_sda = b;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        r = sda_bus;
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        m_sda = 1'b1;
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        clock_bit(1'b1, ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic mack);
        logic r;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            d[i] = r;
        end
        clock_bit(mack, r);
    endtask

    // START, address+W, pointer, then n data bytes from wbuf; the model follows the pointer rules.
    task automatic do_write(input logic [7:0] ptr, input int n, input string tag);
        logic a;
        i2c_start();
        send_byte(AW_BYTE, a);
        check({tag, ":addr_ack"}, a, ACK);
        send_byte(ptr, a);
        check({tag, ":ptr_ack"}, a, ACK);
        ref_ptr = ptr % DEPTH;
        for (int k = 0; k < n; k++) begin
            send_byte(wbuf[k], a);
            check($sformatf("%s:data_ack%0d", tag, k), a, ACK);
            ref_regs[ref_ptr] = wbuf[k];
            ref_ptr = (ref_ptr + 1) % DEPTH;
        end
    endtask

    // (Repeated) START, address+R, n bytes with the last one NACKed.
    task automatic do_read(input int n, input string tag);
        logic       a;
        logic [7:0] d;
        i2c_start();
        send_byte(AR_BYTE, a);
        check({tag, ":raddr_ack"}, a, ACK);
        for (int k = 0; k < n; k++) begin
            recv_byte(d, (k == n - 1) ? NACK : ACK);
            check($sformatf("%s:rd%0d", tag, k), d, ref_regs[ref_ptr]);
            ref_ptr = (ref_ptr + 1) % DEPTH;
        end
    endtask

    task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        loc_addr  = a;
        loc_wdata = d;
        loc_we    = 1'b1;
        @(negedge clk);
        loc_we = 1'b0;
        ref_regs[a] = d;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            loc_addr = 4'(i);
            #1;
            check($sformatf("%s[%0d]", tag, i), loc_rdata, ref_regs[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_regs[i] = 8'h00;
        ref_ptr = 0;
    endtask

    initial begin
        logic       a, r;
        logic [7:0] d, old, rb, ld;
        logic [7:0] p;
        logic [3:0] idx, la;
        int         e0, o0, n;

        // Reset state
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_evt", wr_evt, 1'b0);
        check("rst_idx", wr_idx, 4'd0);
        rst = 1'b1;
        wait_q();
        check_regs("rst_regs");

        // Write 0x11, 0x22 from pointer 3
        e0 = evt_n;
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        do_write(8'h03, 2, "wr34");
        i2c_stop();
        wait_q();
        check("wr34_evt_cnt", evt_n - e0, 2);
        check("wr34_evt_idx0", evt_log[e0 % 64], 4'd3);
        check("wr34_evt_idx1", evt_log[(e0 + 1) % 64], 4'd4);
        check("wr34_reg3", ref_regs[3], 8'h11);
        check_regs("wr34_regs");

        // Pointer write, repeated START, read two bytes
        do_write(8'h03, 0, "rd34");
        do_read(2, "rd34");
        check("rd34_busy_pre_p", busy, 1'b1);
        o0 = oe_cnt;
        i2c_stop();
        wait_q();
        check("rd34_oe_after_nack", oe_cnt - o0, 0);
        check("rd34_busy_post_p", busy, 1'b0);

        // Wrong address
        o0 = oe_cnt;
        e0 = evt_n;
        i2c_start();
        send_byte(8'hB0, a);
        check("badaddr_ack", a, NACK);
        check("badaddr_busy", busy, 1'b0);
        send_byte(8'h05, a);
        i2c_stop();
        wait_q();
        check("badaddr_oe", oe_cnt - o0, 0);
        check("badaddr_evt", evt_n - e0, 0);
        check_regs("badaddr_regs");

        // Pointer wrap; 0x1F selects index 15
        e0 = evt_n;
        wbuf[0] = 8'hAA;
        wbuf[1] = 8'hBB;
        wbuf[2] = 8'hCC;
        do_write(8'h1F, 3, "wrap");
        i2c_stop();
        wait_q();
        check("wrap_evt_idx0", evt_log[e0 % 64], 4'd15);
        check("wrap_evt_idx2", evt_log[(e0 + 2) % 64], 4'd1);
        check_regs("wrap_regs");

        // STOP after four data bits discards the byte
        e0 = evt_n;
        do_write(8'h07, 0, "partial");
        d = 8'h5A;
        for (int i = 7; i >= 4; i--) clock_bit(d[i], r);
        i2c_stop();
        wait_q();
        check("partial_evt", evt_n - e0, 0);
        check_regs("partial_regs");
        i2c_start();
        send_byte(AW_BYTE, a);
        check("partial_reack", a, ACK);
        i2c_stop();

        // Local write while a read byte is in flight does not alter it
        idx = 4'($urandom_range(0, DEPTH - 1));
        old = 8'($urandom);
        loc_write(idx, old);
        do_write({4'h0, idx}, 0, "inflight");
        i2c_start();
        send_byte(AR_BYTE, a);
        check("inflight_raddr_ack", a, ACK);
        rb = 8'h00;
        for (int i = 7; i >= 6; i--) begin
            clock_bit(1'b1, r);
            rb[i] = r;
        end
        loc_write(idx, ~old);
        for (int i = 5; i >= 0; i--) begin
            clock_bit(1'b1, r);
            rb[i] = r;
        end
        clock_bit(NACK, r);
        i2c_stop();
        check("inflight_byte", rb, old);
        check_regs("inflight_regs");

        // Randomized write / read-back transactions
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 4);
            p = 8'($urandom);
            for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
            e0 = evt_n;
            do_write(p, n, $sformatf("rnd%0d_w", it));
            i2c_stop();
            wait_q();
            check($sformatf("rnd%0d_evt_cnt", it), evt_n - e0, n);
            check($sformatf("rnd%0d_evt_idx0", it), evt_log[e0 % 64], 4'(p % DEPTH));
            la = 4'($urandom);
            ld = 8'($urandom);
            loc_write(la, ld);
            do_write(p, 0, $sformatf("rnd%0d_p", it));
            do_read(n + 1, $sformatf("rnd%0d_r", it));
            i2c_stop();
            wait_q();
            check($sformatf("rnd%0d_busy", it), busy, 1'b0);
        end
        check_regs("rnd_regs");

        // Asynchronous reset while the target drives an address ACK
        d = AW_BYTE;
        i2c_start();
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        m_sda = 1'b1;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        check("arst_pre_oe", sda_oe, 1'b1);
        check("arst_pre_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("arst_oe", sda_oe, 1'b0);
        check("arst_busy", busy, 1'b0);
        model_reset();
        check_regs("arst_regs");
        @(negedge clk);
        rst = 1'b1;
        wait_q();
        m_scl = 1'b0;
        wait_q();
        o0 = oe_cnt;
        send_byte(AW_BYTE, a);
        check("arst_nostart_ack", a, NACK);
        check("arst_nostart_oe", oe_cnt - o0, 0);
        i2c_start();
        send_byte(AW_BYTE, a);
        check("arst_fresh_ack", a, ACK);
        i2c_stop();
        wait_q();
        check("arst_final_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
